ioctl_dl_bridge: RTL and testbench
==================================

// Module: ioctl_dl_bridge
// PURPOSE
//  Buffered, multi-channel successor to the bare ioctl download path in the sim top level.
//  Captures host ioctl writes into a FIFO and throttles the host with ioctl_wait near full.
//  Routes each beat to one of NCH consumer channels (BIOS, cart, RAM...) by ioctl_index.
//  Signals a single dl_done pulse once a download has ended and fully drained.
// PARAMETERS
//  ADDR_W      25  ioctl address width
//  NCH         4   consumer channels; channel = ioctl_index[CH_W-1:0], CH_W = $clog2(NCH)
//  DEPTH       16  FIFO entries, power of two, >= 4
//  WAIT_MARGIN 2   ioctl_wait asserts when count >= DEPTH-WAIT_MARGIN
// PORTS
//  clk_sys        in  1        system clock
//  reset          in  1        asynchronous, active-high reset
//  ioctl_download in  1        host download active
//  ioctl_wr       in  1        host write strobe, one cycle per byte
//  ioctl_addr     in  ADDR_W   byte address
//  ioctl_dout     in  8        byte data
//  ioctl_index    in  8        target index
//  ioctl_wait     out 1        backpressure to host
//  dl_valid       out NCH      one-hot beat valid for the selected channel
//  dl_ready       in  NCH      per-channel consumer ready
//  dl_addr        out ADDR_W   beat address
//  dl_data        out 8        beat data
//  dl_first       out 1        beat is the first of the current download
//  dl_done        out 1        one-cycle pulse: download ended and FIFO empty
//  dl_err         out 1        sticky: overflow or out-of-range index seen
//  dl_sum         out 16       running byte sum (IOCTL_CHECKSUM_EN only)
// BEHAVIOUR
//  - Reset: ioctl_wait=0, dl_valid=0, dl_addr=0, dl_data=0, dl_first=0, dl_done=0, dl_err=0,
//    dl_sum=0; FIFO empty, FSM IDLE. Reset mid-download discards all buffered beats.
//  - Enqueue: ioctl_wr & ioctl_download pushes {addr,data,ch,first}; ioctl_wr with
//    ioctl_download low is ignored. Index >= NCH: beat dropped, dl_err set.
//  - Full: write when count==DEPTH is dropped, dl_err set; FIFO contents unchanged.
//  - Latency: write at cycle N into empty FIFO -> head visible (dl_valid) at N+1.
//  - Dequeue: pop when dl_valid[ch] & dl_ready[ch]; head held stable until popped.
//    Simultaneous push+pop at full: push accepted, count unchanged.
//  - ioctl_wait is registered: 1 when count >= DEPTH-WAIT_MARGIN or FSM==DRAIN, else 0.
//  - FSM: IDLE -(download rise)-> LOAD -(download fall)-> DRAIN -(FIFO empty)-> DONE
//    -(next cycle)-> IDLE. dl_done=1 only in DONE. Download rise during DRAIN/DONE:
//    go to LOAD, previous dl_done suppressed, new beats enqueue behind old ones.
//  - dl_first set on the first accepted beat after each download rise.
//  - Pointers wrap mod DEPTH; count is $clog2(DEPTH)+1 bits.
// CONFIGURATION
//  - IOCTL_CHECKSUM_EN defined: dl_sum = 16-bit wrapping sum of dl_data over popped beats,
//    cleared on download rise, frozen after DONE.
//  - Not defined: dl_sum tied to 0, no adder logic generated.
// STRUCTURE
//  - Package ioctl_pkg: FSM state enum (IDLE, LOAD, DRAIN, DONE), beat struct
//    {addr, data, ch, first}, channel-width constant helper.
//  - Sub-module ioctl_fifo: synchronous FIFO, DEPTH x beat, push/pop/full/empty/count.
//  - Top handles FSM, index decode, wait generation, one-hot valid and checksum.
// TESTING
//  - 8 writes idx 1, all dl_ready=1 -> 8 beats on dl_valid[1], first flagged, dl_done once.
//  - dl_ready=0, 14 writes, DEPTH=16 -> ioctl_wait=1 after count hits 14; release -> wait=0.
//  - 17 writes to stalled FIFO ignoring wait -> 17th dropped, dl_err=1, 16 beats delivered.
//  - write idx 5 with NCH=4 -> no beat, dl_err=1, other channels unaffected.
//  - reset asserted with 6 beats buffered -> all outputs to reset values next edge, no beats.
//  - IOCTL_CHECKSUM_EN, bytes 0xFF x 300 -> dl_sum = 0x2AD4 after drain.

Source files
------------

// File: rtl/ioctl_pkg.sv
// Shared types for the ioctl download bridge: FSM states, default beat layout
// and the channel-select width helper.
package ioctl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  function automatic int ch_width(input int nch);
    return (nch > 1) ? $clog2(nch) : 1;
  endfunction

  localparam int DEF_ADDR_W = 25;
  localparam int DEF_NCH    = 4;

  // Beat layout for the default configuration; the top derives its own from its parameters.
  typedef struct packed {
    logic [DEF_ADDR_W-1:0]        addr;
    logic [7:0]                   data;
    logic [ch_width(DEF_NCH)-1:0] ch;
    logic                         first;
  } beat_t;

endpackage

// File: rtl/ioctl_fifo.sv
// Synchronous FIFO of download beats with first-word-fall-through head and
// occupancy count; a push while full is only accepted alongside a pop.
module ioctl_fifo
  import ioctl_pkg::*;
#(
  parameter type entry_t = beat_t,
  parameter int  DEPTH   = 16,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  entry_t        din,
  input  logic          pop,
  output entry_t        head,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  entry_t          mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic            do_push, do_pop;

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  // Head reads as zero when empty so the bridge outputs idle at zero.
  assign head  = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/ioctl_dl_bridge.sv
// Buffered multi-channel ioctl download bridge: FIFO capture, host throttling,
// per-index routing and end-of-download pulse. Define IOCTL_CHECKSUM_EN for dl_sum.
module ioctl_dl_bridge
  import ioctl_pkg::*;
#(
  parameter int ADDR_W      = 25,
  parameter int NCH         = 4,
  parameter int DEPTH       = 16,
  parameter int WAIT_MARGIN = 2
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ioctl_download,
  input  logic              ioctl_wr,
  input  logic [ADDR_W-1:0] ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  input  logic [7:0]        ioctl_index,
  output logic              ioctl_wait,
  output logic [NCH-1:0]    dl_valid,
  input  logic [NCH-1:0]    dl_ready,
  output logic [ADDR_W-1:0] dl_addr,
  output logic [7:0]        dl_data,
  output logic              dl_first,
  output logic              dl_done,
  output logic              dl_err,
  output logic [15:0]       dl_sum
);

  localparam int CH_W = ch_width(NCH);
  localparam int AW   = $clog2(DEPTH);
  localparam logic [AW:0] WAIT_THR = (AW+1)'(DEPTH - WAIT_MARGIN);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data;
    logic [CH_W-1:0]   ch;
    logic              first;
  } dl_beat_t;

  state_t      state_q, state_d;
  logic        dl_prev_q;
  logic        first_pend_q, first_pend_d;
  logic        err_q, err_d;
  logic        wait_q, wait_d;
  logic        dl_rise, dl_fall;
  logic        idx_ok, wr_live, wr_ok, accepted, pop;
  dl_beat_t    beat_in, head;
  logic        fifo_full, fifo_empty;
  logic [AW:0] fifo_count;

  assign dl_rise = ioctl_download && !dl_prev_q;
  assign dl_fall = !ioctl_download && dl_prev_q;
  assign idx_ok  = int'(ioctl_index) < NCH;
  assign wr_live = ioctl_wr && ioctl_download;
  assign wr_ok   = wr_live && idx_ok;
  assign pop     = |(dl_valid & dl_ready);
  assign accepted = wr_ok && (!fifo_full || pop);

  always_comb begin
    beat_in       = '0;
    beat_in.addr  = ioctl_addr;
    beat_in.data  = ioctl_dout;
    beat_in.ch    = ioctl_index[CH_W-1:0];
    beat_in.first = first_pend_q || dl_rise;
  end

  ioctl_fifo #(
    .entry_t (dl_beat_t),
    .DEPTH   (DEPTH)
  ) u_fifo (
    .clk   (clk_sys),
    .rst   (reset),
    .push  (wr_ok),
    .din   (beat_in),
    .pop   (pop),
    .head  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  for (genvar gi = 0; gi < NCH; gi++) begin : g_valid
    assign dl_valid[gi] = !fifo_empty && (head.ch == CH_W'(gi));
  end

  assign dl_addr    = head.addr;
  assign dl_data    = head.data;
  assign dl_first   = head.first;
  assign dl_err     = err_q;
  assign ioctl_wait = wait_q;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (dl_rise) state_d = LOAD;
      LOAD:    if (dl_fall) state_d = DRAIN;
      DRAIN:   if (dl_rise) state_d = LOAD;
               else if (fifo_empty) state_d = DONE;
      DONE:    state_d = dl_rise ? LOAD : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A new download starting in DONE cancels the pending completion pulse.
  always_comb begin
    dl_done = (state_q == DONE) && !dl_rise;
    wait_d  = (fifo_count >= WAIT_THR) || (state_q == DRAIN);
  end

  always_comb begin
    first_pend_d = first_pend_q;
    if (accepted)     first_pend_d = 1'b0;
    else if (dl_rise) first_pend_d = 1'b1;
    err_d = err_q || (wr_live && !idx_ok) || (wr_ok && fifo_full && !pop);
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      dl_prev_q    <= 1'b0;
      first_pend_q <= 1'b0;
      err_q        <= 1'b0;
      wait_q       <= 1'b0;
    end else begin
      dl_prev_q    <= ioctl_download;
      first_pend_q <= first_pend_d;
      err_q        <= err_d;
      wait_q       <= wait_d;
    end
  end

`ifdef IOCTL_CHECKSUM_EN
  logic [15:0] sum_q, sum_d;

  always_comb begin
    sum_d = sum_q;
    if (dl_rise)
      sum_d = '0;
    else if (pop && (state_q == LOAD || state_q == DRAIN))
      sum_d = sum_q + {8'h00, head.data};
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) sum_q <= '0;
    else       sum_q <= sum_d;
  end

  assign dl_sum = sum_q;
`else
  assign dl_sum = '0;
`endif

endmodule

// File: tb/tb_ioctl_dl_bridge.sv
// Scoreboard bench for ioctl_dl_bridge: accepted writes queue expected beats,
// the monitor pops and compares every delivered beat.
`timescale 1ns/1ps
module tb_ioctl_dl_bridge;

  localparam int ADDR_W = 25;
  localparam int NCH    = 4;
  localparam int DEPTH  = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              ioctl_download;
  logic              ioctl_wr;
  logic [ADDR_W-1:0] ioctl_addr;
  logic [7:0]        ioctl_dout;
  logic [7:0]        ioctl_index;
  logic              ioctl_wait;
  logic [NCH-1:0]    dl_valid;
  logic [NCH-1:0]    dl_ready;
  logic [ADDR_W-1:0] dl_addr;
  logic [7:0]        dl_data;
  logic              dl_first;
  logic              dl_done;
  logic              dl_err;
  logic [15:0]       dl_sum;

  always #5 clk = ~clk;

  ioctl_dl_bridge #(
    .ADDR_W(ADDR_W), .NCH(NCH), .DEPTH(DEPTH), .WAIT_MARGIN(2)
  ) dut (
    .clk_sys        (clk),
    .reset          (rst),
    .ioctl_download (ioctl_download),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .ioctl_index    (ioctl_index),
    .ioctl_wait     (ioctl_wait),
    .dl_valid       (dl_valid),
    .dl_ready       (dl_ready),
    .dl_addr        (dl_addr),
    .dl_data        (dl_data),
    .dl_first       (dl_first),
    .dl_done        (dl_done),
    .dl_err         (dl_err),
    .dl_sum         (dl_sum)
  );

  typedef struct {
    int                ch;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data;
    logic              first;
  } exp_t;

  exp_t        sb[$];
  int          n_chk = 0;
  int          n_fail = 0;
  int          n_beats = 0;
  int          n_done = 0;
  logic        first_pend = 1'b0;
  logic [15:0] model_sum = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drive one write for one cycle and record what the bridge should do with it.
  task automatic wr(input int idx, input logic [ADDR_W-1:0] a, input logic [7:0] d);
    exp_t e;
    logic pop_now;
    ioctl_wr    = 1'b1;
    ioctl_index = 8'(idx);
    ioctl_addr  = a;
    ioctl_dout  = d;
    pop_now = (sb.size() > 0) && dl_ready[sb[0].ch];
    if (ioctl_download && idx < NCH && (sb.size() < DEPTH || pop_now)) begin
      e.ch = idx; e.addr = a; e.data = d; e.first = first_pend;
      sb.push_back(e);
      first_pend = 1'b0;
      model_sum  = model_sum + {8'h00, d};
    end
    tick(1);
    ioctl_wr = 1'b0;
  endtask

  task automatic dl_on();
    ioctl_download = 1'b1;
    first_pend     = 1'b1;
    model_sum      = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ioctl_download = 1'b0;
    ioctl_wr = 1'b0;
    sb.delete();
    first_pend = 1'b0;
    model_sum  = '0;
    tick(2);
    rst = 1'b0;
    tick(1);
    n_beats = 0;
    n_done  = 0;
  endtask

  task automatic wait_drain(input int max);
    int k = 0;
    while (sb.size() != 0 && k < max) begin
      tick(1);
      k++;
    end
    chk("drain", sb.size(), 0);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst) begin
      if (dl_done) n_done++;
      if ((dl_valid & dl_ready) != '0) begin
        if (sb.size() == 0) begin
          chk("unexpected_beat", 32'(dl_valid), 0);
        end else begin
          e = sb.pop_front();
          $display("beat ch=%0d addr=%h data=%h first=%0b", e.ch, dl_addr, dl_data, dl_first);
          chk("beat_valid", 32'(dl_valid), 32'(1) << e.ch);
          chk("beat_addr", 32'(dl_addr), 32'(e.addr));
          chk("beat_data", 32'(dl_data), 32'(e.data));
          chk("beat_first", 32'(dl_first), 32'(e.first));
          n_beats++;
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [15:0] exp_sum;
    ioctl_addr = '0; ioctl_dout = '0; ioctl_index = '0; dl_ready = '0;
    do_reset();

    // Reset state
    chk("rst_wait", 32'(ioctl_wait), 0);
    chk("rst_valid", 32'(dl_valid), 0);
    chk("rst_addr", 32'(dl_addr), 0);
    chk("rst_data", 32'(dl_data), 0);
    chk("rst_first", 32'(dl_first), 0);
    chk("rst_done", 32'(dl_done), 0);
    chk("rst_err", 32'(dl_err), 0);
    chk("rst_sum", 32'(dl_sum), 0);

    // 8 beats to channel 1, consumers always ready
    dl_ready = '1;
    wr(1, 25'h0AA, 8'h55);
    tick(2);
    chk("wr_ignored_no_dl", 32'(n_beats), 0);
    dl_on();
    tick(1);
    wr(1, 25'h100, 8'h03);
    chk("latency_valid", 32'(dl_valid), 32'b0010);
    for (int i = 1; i < 8; i++) wr(1, 25'h100 + 25'(i), 8'(i * 7 + 3));
    ioctl_download = 1'b0;
    wait_drain(64);
    tick(5);
    chk("t1_beats", n_beats, 8);
    chk("t1_done_pulses", n_done, 1);
    chk("t1_err", 32'(dl_err), 0);

    // Backpressure threshold with stalled consumers
    do_reset();
    dl_ready = '0;
    dl_on();
    for (int i = 0; i < 13; i++) wr(2, 25'h200 + 25'(i), 8'(8'hA0 + i));
    tick(2);
    chk("t2_wait_13", 32'(ioctl_wait), 0);
    wr(2, 25'h20D, 8'hAD);
    tick(2);
    chk("t2_wait_14", 32'(ioctl_wait), 1);
    dl_ready = '1;
    wait_drain(64);
    tick(2);
    chk("t2_wait_released", 32'(ioctl_wait), 0);
    ioctl_download = 1'b0;
    tick(6);
    chk("t2_beats", n_beats, 14);
    chk("t2_done_pulses", n_done, 1);

    // Overflow: 17 writes into a stalled 16-deep FIFO
    do_reset();
    dl_ready = '0;
    dl_on();
    for (int i = 0; i < 17; i++) wr(3, 25'h300 + 25'(i), 8'(i));
    tick(1);
    chk("t3_err", 32'(dl_err), 1);
    chk("t3_wait", 32'(ioctl_wait), 1);
    dl_ready = '1;
    wait_drain(64);
    chk("t3_beats", n_beats, 16);
    ioctl_download = 1'b0;
    tick(6);

    // Out-of-range index
    do_reset();
    dl_ready = '1;
    dl_on();
    wr(5, 25'h500, 8'h77);
    tick(1);
    chk("t4_err", 32'(dl_err), 1);
    chk("t4_no_beat", n_beats, 0);
    wr(0, 25'h010, 8'h11);
    wr(3, 25'h013, 8'h33);
    wait_drain(32);
    chk("t4_beats", n_beats, 2);
    ioctl_download = 1'b0;
    tick(6);

    // Reset with beats buffered
    do_reset();
    dl_ready = '0;
    dl_on();
    for (int i = 0; i < 6; i++) wr(1, 25'h600 + 25'(i), 8'(8'hC0 + i));
    tick(1);
    chk("t5_buffered_valid", 32'(dl_valid), 32'b0010);
    rst = 1'b1;
    ioctl_download = 1'b0;
    sb.delete();
    first_pend = 1'b0;
    #2;
    chk("t5_valid", 32'(dl_valid), 0);
    chk("t5_addr", 32'(dl_addr), 0);
    chk("t5_data", 32'(dl_data), 0);
    chk("t5_first", 32'(dl_first), 0);
    chk("t5_wait", 32'(ioctl_wait), 0);
    chk("t5_err", 32'(dl_err), 0);
    tick(2);
    rst = 1'b0;
    n_beats = 0;
    dl_ready = '1;
    tick(10);
    chk("t5_no_beats", n_beats, 0);

    // 300 x 0xFF, checksum when enabled
    do_reset();
    dl_ready = '1;
    dl_on();
    for (int i = 0; i < 300; i++) wr(0, 25'(i), 8'hFF);
    ioctl_download = 1'b0;
    wait_drain(64);
    tick(5);
`ifdef IOCTL_CHECKSUM_EN
    exp_sum = model_sum;
`else
    exp_sum = '0;
`endif
    chk("t6_sum", 32'(dl_sum), 32'(exp_sum));
    chk("t6_beats", n_beats, 300);
    chk("t6_done_pulses", n_done, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
